mem_access_stage: RTL and testbench

Memory stage directly downstream of the execute stage. Consumes the ALU result (effective address or pass-through value) together with store data and funct3. Performs RV32I byte, half and word loads and stores over a req/ack data-memory port, sign- or zero-extending load data. Hands the writeback value to the writeback stage through a valid/ready handshake.

---
 rtl/mem_access_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I load/store memory stage with req/ack memory port and valid/ready writeback
module mem_access_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           aluout,
  input  logic [31:0]           store_data,
  input  logic [2:0]            funct3,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [4:0]            rd,
  input  logic                  regwrite,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [4:0]            out_rd,
  output logic                  out_regwrite,
  output logic                  access_fault,
  output logic                  timeout_fault
);
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  state_t state_q, state_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d, out_data_q, out_data_d;
  logic [3:0] mem_wstrb_q, mem_wstrb_d;
  logic out_valid_q, out_valid_d, out_regwrite_q, out_regwrite_d;
  logic access_fault_q, access_fault_d, timeout_fault_q, timeout_fault_d;
  logic [4:0] out_rd_q, out_rd_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic rw_q, rw_d;
  logic ill;
  logic [31:0] sh, ld, wdata;
  logic [3:0] wstrb;
  assign in_ready = (state_q == IDLE) && !rst;
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_rd = out_rd_q;
  assign out_regwrite = out_regwrite_q;
  assign access_fault = access_fault_q;
  assign timeout_fault = timeout_fault_q;
  always_comb begin
    ill = (memread && memwrite) || (funct3[1:0] == 2'b11) || (memwrite && funct3[2]) ||
          (memread && funct3 == 3'b110) || (funct3[1:0] == 2'b01 && aluout[0]) ||
          (funct3[1:0] == 2'b10 && aluout[1:0] != 2'b00);
    wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
            funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    wstrb = !memwrite ? 4'b0000 :
            funct3[1:0] == 2'b00 ? 4'b0001 << aluout[1:0] :
            funct3[1:0] == 2'b01 ? 4'b0011 << {aluout[1], 1'b0} : 4'b1111;
    sh = mem_rdata >> {off_q, 3'b000};
    ld = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
         f3_q == 3'b100 ? {24'b0, sh[7:0]} :
         f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
         f3_q == 3'b101 ? {16'b0, sh[15:0]} : sh;
    state_d = state_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_rd_d = out_rd_q;
    out_regwrite_d = out_regwrite_q;
    access_fault_d = 1'b0;
    timeout_fault_d = 1'b0;
    cnt_d = cnt_q;
    f3_d = f3_q;
    off_d = off_q;
    rw_d = rw_q;
    if (state_q == IDLE && in_valid) begin
      out_rd_d = rd;
      f3_d = funct3;
      off_d = aluout[1:0];
      rw_d = regwrite;
      cnt_d = '0;
      if (!memread && !memwrite) begin
        out_data_d = aluout;
        out_regwrite_d = regwrite;
        out_valid_d = 1'b1;
        state_d = HOLD;
      end else if (ill) begin
        access_fault_d = 1'b1;
        out_data_d = aluout;
        out_regwrite_d = 1'b0;
        out_valid_d = 1'b1;
        state_d = HOLD;
      end else begin
        mem_req_d = 1'b1;
        mem_we_d = memwrite;
        mem_addr_d = {aluout[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_d = wdata;
        mem_wstrb_d = wstrb;
        state_d = ACCESS;
      end
    end else if (state_q == ACCESS) begin
      if (mem_ack) begin
        mem_req_d = 1'b0;
        out_valid_d = 1'b1;
        out_regwrite_d = !mem_we_q && rw_q;
        out_data_d = mem_we_q ? out_data_q : ld;
        state_d = HOLD;
      end else if (cnt_q + 8'd1 == MW) begin
        mem_req_d = 1'b0;
        timeout_fault_d = 1'b1;
        out_regwrite_d = 1'b0;
        out_valid_d = 1'b1;
        state_d = HOLD;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (state_q == HOLD && out_ready) begin
      out_valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_rd_q <= '0;
      out_regwrite_q <= 1'b0;
      access_fault_q <= 1'b0;
      timeout_fault_q <= 1'b0;
      cnt_q <= '0;
      f3_q <= '0;
      off_q <= '0;
      rw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_rd_q <= out_rd_d;
      out_regwrite_q <= out_regwrite_d;
      access_fault_q <= access_fault_d;
      timeout_fault_q <= timeout_fault_d;
      cnt_q <= cnt_d;
      f3_q <= f3_d;
      off_q <= off_d;
      rw_q <= rw_d;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized self-checking bench against a behavioural load/store model
module tb_mem_access_stage;
  localparam int MW = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] aluout = '0, store_data = '0;
  logic [2:0] funct3 = '0;
  logic memread = 1'b0, memwrite = 1'b0, regwrite = 1'b0;
  logic [4:0] rd = '0;
  logic mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0] mem_wstrb;
  logic out_valid, out_ready = 1'b0, out_regwrite, access_fault, timeout_fault;
  logic [31:0] out_data;
  logic [4:0] out_rd;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_access_stage #(.ADDR_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .aluout(aluout),
    .store_data(store_data), .funct3(funct3), .memread(memread), .memwrite(memwrite),
    .rd(rd), .regwrite(regwrite), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .access_fault(access_fault), .timeout_fault(timeout_fault)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic lq, input logic sq, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdat, input logic [4:0] r,
                       input logic rw, input int dly, input int hold);
    int nb;
    bit ill, mem, tmo, cd, crd;
    logic [31:0] ed, ewd;
    logic [3:0] ews;
    logic erw;
    longint v;
    nb = 1 << f3[1:0];
    mem = lq || sq;
    ill = (lq && sq) || f3[1:0] == 2'b11 || (sq && f3[2]) || (lq && f3 == 3'b110) || (a % nb != 0);
    tmo = dly >= MW;
    ews = sq ? 4'(((1 << nb) - 1) << (a % 4)) : 4'h0;
    for (int j = 0; j < 4; j++) ewd[8*j +: 8] = sd[8*(j % nb) +: 8];
    v = longint'(rdat >> (8 * (a % 4))) & ((longint'(1) << (8 * nb)) - 1);
    if (!f3[2] && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    ed = 32'(v);
    erw = 1'b0;
    cd = 1'b0;
    crd = 1'b0;
    if (!mem) begin
      ed = a; erw = rw; cd = 1'b1; crd = 1'b1;
    end else if (ill) begin
      ed = a; cd = 1'b1;
    end else if (!tmo && !sq) begin
      erw = rw; cd = 1'b1; crd = 1'b1;
    end
    chk("in_ready_pre", in_ready, 1);
    in_valid = 1'b1; memread = lq; memwrite = sq; funct3 = f3; aluout = a;
    store_data = sd; rd = r; regwrite = rw;
    tick;
    in_valid = 1'b0; memread = 1'($urandom); memwrite = 1'($urandom); funct3 = 3'($urandom);
    aluout = $urandom; store_data = $urandom; rd = 5'($urandom); regwrite = 1'($urandom);
    if (mem && !ill) begin
      for (int i = 0; i <= dly && i < MW; i++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, sq);
        chk("mem_addr", mem_addr, a & ~32'h3);
        chk("mem_wstrb", mem_wstrb, ews);
        if (sq) chk("mem_wdata", mem_wdata, ewd);
        chk("out_valid_busy", out_valid, 0);
        chk("in_ready_busy", in_ready, 0);
        if (i == dly) begin
          mem_ack = 1'b1;
          mem_rdata = rdat;
        end
        tick;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end
    chk("mem_req_done", mem_req, 0);
    chk("out_valid", out_valid, 1);
    chk("access_fault", access_fault, mem && ill);
    chk("timeout_fault", timeout_fault, mem && !ill && tmo);
    chk("out_regwrite", out_regwrite, erw);
    if (cd) chk("out_data", out_data, ed);
    if (crd) chk("out_rd", out_rd, r);
    chk("in_ready_hold", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      mem_ack = 1'($urandom);
      tick;
      mem_ack = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_faults", {access_fault, timeout_fault, mem_req}, 0);
      chk("hold_regwrite", out_regwrite, erw);
      if (cd) chk("hold_data", out_data, ed);
      if (crd) chk("hold_rd", out_rd, r);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_post", in_ready, 1);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ctrl", {mem_req, mem_we, out_valid, out_regwrite, access_fault, timeout_fault}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1);
    do_op(1, 0, 3'b000, 32'h103, 0, 32'h80AABBCC, 5'd1, 1, 1, 0);
    do_op(1, 0, 3'b100, 32'h103, 0, 32'h80AABBCC, 5'd2, 1, 1, 0);
    do_op(1, 0, 3'b001, 32'h102, 0, 32'h80AABBCC, 5'd3, 1, 1, 1);
    do_op(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 5'd4, 1, 0, 0);
    do_op(0, 1, 3'b000, 32'h201, 32'h0000005A, 0, 5'd4, 1, 2, 0);
    do_op(1, 0, 3'b010, 32'h101, 0, 0, 5'd6, 1, 0, 1);
    do_op(1, 1, 3'b010, 32'h100, 0, 0, 5'd6, 1, 0, 1);
    do_op(1, 0, 3'b010, 32'h104, 0, 32'hCAFEF00D, 5'd7, 1, 3, 0);
    do_op(1, 0, 3'b010, 32'h108, 0, 32'h12345678, 5'd8, 1, MW - 1, 0);
    do_op(1, 0, 3'b010, 32'h10C, 0, 32'h0, 5'd9, 1, 100, 2);
    do_op(0, 0, 3'b010, 32'hDEADBEEF, 0, 0, 5'd5, 1, 0, 5);
    in_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; aluout = 32'h300;
    rd = 5'd3; regwrite = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("pre_rst_req", mem_req, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {mem_req, out_valid, access_fault, timeout_fault}, 0);
    chk("mid_rst_ready", in_ready, 1);
    mem_ack = 1'b1;
    mem_rdata = 32'h55AA55AA;
    tick;
    mem_ack = 1'b0;
    chk("stray_ack_ctrl", {mem_req, out_valid, access_fault, timeout_fault}, 0);
    chk("stray_ack_ready", in_ready, 1);
    do_op(1, 0, 3'b010, 32'h300, 0, 32'h0BADF00D, 5'd3, 1, 1, 0);
    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(0, 15);
      do_op(k inside {[1:6], 15}, k inside {[7:12], 15}, 3'($urandom), $urandom, $urandom,
            $urandom, 5'($urandom), 1'($urandom),
            ($urandom_range(0, 19) == 0) ? MW + $urandom_range(0, 3) : $urandom_range(0, 4),
            $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
